// File: rtl/line_burst_adapter.sv
// rtl/line_burst_adapter.sv - cache line port to burst memory port adapter
//
// Purpose: accepts one cache line read or write request at a time and turns it
// into a burst of BEATS = LINE_W/BURST_W memory beats, lowest beat first. Read
// beats are assembled into a line buffer and returned with a one-cycle
// line_resp_o pulse; write lines are buffered at accept and streamed out beat
// by beat.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   line_read_i    line read request, held until line_resp_o
//   line_write_i   line write request, held until line_resp_o
//   line_addr_i    line byte address (offset bits ignored)
//   line_wdata_i   write line, sampled when the request is accepted
//   line_rdata_o   last read line, updated together with line_resp_o
//   line_resp_o    one-cycle completion pulse
//   mem_read_o     burst read in progress
//   mem_write_o    burst write in progress
//   mem_addr_o     line-aligned burst address
//   mem_wdata_o    current write beat
//   mem_rdata_i    read beat data, valid with mem_resp_i
//   mem_resp_i     one beat transferred this cycle
module line_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  // Clearing the offset with a mask keeps every address bit in use.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF) - 64'd1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  buf_q, buf_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               mem_read_q, mem_write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        // Read has priority; a simultaneous write is simply not accepted.
        if (line_read_i) begin
          addr_d  = line_addr_i & LINE_MASK;
          state_d = S_READ;
        end else if (line_write_i) begin
          addr_d  = line_addr_i & LINE_MASK;
          buf_d   = line_wdata_i;
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (mem_resp_i) begin
          buf_d[cnt_q*BURST_W +: BURST_W] = mem_rdata_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // Publish the assembled line (including this last beat) so it is
            // valid in the same cycle as the response pulse.
            rdata_d = buf_d;
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (mem_resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      // Decoded from the next state so the strobes track the FSM exactly and
      // fall in the cycle right after the last beat.
      mem_read_q  <= (state_d == S_READ);
      mem_write_q <= (state_d == S_WRITE);
    end
  end

  assign line_rdata_o = rdata_q;
  assign line_resp_o  = (state_q == S_DONE);
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = buf_q[cnt_q*BURST_W +: BURST_W];

endmodule

// File: tb/tb_line_burst_adapter.sv
// tb/tb_line_burst_adapter.sv - scoreboard bench for line_burst_adapter (256b and 512b lines)
module tb_line_burst_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int LW  = (g == 0) ? 256 : 512;
    localparam int BW  = 64;
    localparam int NB  = LW / BW;
    localparam int OFF = $clog2(LW / 8);

    logic           rst;
    logic           line_read_i, line_write_i;
    logic [31:0]    line_addr_i;
    logic [LW-1:0]  line_wdata_i, line_rdata_o;
    logic           line_resp_o;
    logic           mem_read_o, mem_write_o;
    logic [31:0]    mem_addr_o;
    logic [BW-1:0]  mem_wdata_o, mem_rdata_i;
    logic           mem_resp_i;

    line_burst_adapter #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .line_read_i  (line_read_i),
      .line_write_i (line_write_i),
      .line_addr_i  (line_addr_i),
      .line_wdata_i (line_wdata_i),
      .line_rdata_o (line_rdata_o),
      .line_resp_o  (line_resp_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_resp_i   (mem_resp_i)
    );

    // Reference state: beats the memory still owes / expects, expected responses.
    logic [BW-1:0] rd_beats_q[$];
    logic [BW-1:0] wr_beats_q[$];
    bit            exp_kind_q[$];
    logic [LW-1:0] exp_line_q[$];
    logic [31:0]   cur_addr;
    logic [LW-1:0] last_rd;
    int            gap_pct;
    bit            fin;
    bit            prev_resp;

    function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
      return {$urandom, $urandom};
    endfunction

    task automatic chk_reset_outputs();
      chk("rst_line_rdata", line_rdata_o, '0);
      chk("rst_line_resp", line_resp_o, 0);
      chk("rst_mem_read", mem_read_o, 0);
      chk("rst_mem_write", mem_write_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input bit do_reset);
      logic [LW-1:0] wd, line;
      logic [BW-1:0] beat;
      int n;
      @(negedge clk);
      wd = rand_line();
      line = '0;
      cur_addr = (addr / (LW / 8)) * (LW / 8);
      if (rd) begin
        for (int i = 0; i < NB; i++) begin
          beat = rand_beat();
          rd_beats_q.push_back(beat);
          line[i*BW +: BW] = beat;
        end
        if (!do_reset) begin
          exp_kind_q.push_back(1'b1);
          exp_line_q.push_back(line);
        end
      end else begin
        for (int i = 0; i < NB; i++) wr_beats_q.push_back(wd[i*BW +: BW]);
        exp_kind_q.push_back(1'b0);
        exp_line_q.push_back(line);
      end
      line_read_i  = rd;
      line_write_i = wr;
      line_addr_i  = addr;
      line_wdata_i = wd;
      n = 0;
      if (do_reset) begin
        while (rd_beats_q.size() > NB - 2 && n < 300) begin
          @(posedge clk);
          #2;
          n++;
        end
        chk("two_beats_before_reset", n < 300, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        rd_beats_q.delete();
        last_rd = '0;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end else begin
        while (n < 300) begin
          @(negedge clk);
          if (line_resp_o) break;
          // Inputs wander mid-burst; the latched copies must be used.
          line_addr_i  = $urandom;
          line_wdata_i = rand_line();
          n++;
        end
        chk("resp_in_time", n < 300, 1);
        @(posedge clk);
        #1;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
      end
    endtask

    // Memory responder and burst-side checker.
    initial begin
      mem_resp_i  = 1'b0;
      mem_rdata_i = '0;
      forever begin
        @(negedge clk);
        mem_resp_i  = 1'b0;
        mem_rdata_i = rand_beat();
        if (mem_read_o || mem_write_o) begin
          chk("op_exclusive", mem_read_o & mem_write_o, 0);
          chk("mem_addr", mem_addr_o, cur_addr);
          if (mem_read_o) chk("read_op_has_beats_left", rd_beats_q.size() != 0, 1);
          else            chk("write_op_has_beats_left", wr_beats_q.size() != 0, 1);
          if ($urandom_range(0, 99) >= gap_pct) begin
            if (mem_read_o && rd_beats_q.size() != 0) begin
              mem_resp_i  = 1'b1;
              mem_rdata_i = rd_beats_q.pop_front();
            end else if (mem_write_o && wr_beats_q.size() != 0) begin
              mem_resp_i = 1'b1;
              chk("mem_wdata", mem_wdata_o, wr_beats_q.pop_front());
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          // Stray beat while no burst is active must be ignored.
          mem_resp_i = 1'b1;
        end
      end
    end

    // Line-side monitor.
    initial begin
      bit k;
      logic [LW-1:0] l;
      prev_resp = 1'b0;
      forever begin
        @(negedge clk);
        if (line_resp_o) begin
          chk("resp_single_cycle", prev_resp, 0);
          chk("resp_expected", exp_kind_q.size() != 0, 1);
          if (exp_kind_q.size() != 0) begin
            k = exp_kind_q.pop_front();
            l = exp_line_q.pop_front();
            chk("beats_all_transferred", rd_beats_q.size() + wr_beats_q.size(), 0);
            if (k) begin
              chk("line_rdata", line_rdata_o, l);
              last_rd = l;
            end else begin
              chk("line_rdata_held", line_rdata_o, last_rd);
            end
          end
        end
        prev_resp = line_resp_o;
      end
    end

    // Stimulus.
    initial begin
      bit r, w;
      fin          = 1'b0;
      rst          = 1'b0;
      line_read_i  = 1'b0;
      line_write_i = 1'b0;
      line_addr_i  = '0;
      line_wdata_i = '0;
      last_rd      = '0;
      cur_addr     = '0;
      gap_pct      = 0;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b1;
      do_req(1, 0, 32'h0000_1234, 0);
      gap_pct = 50;
      do_req(1, 0, $urandom, 0);
      gap_pct = 0;
      do_req(0, 1, $urandom, 0);
      gap_pct = 40;
      do_req(0, 1, $urandom, 0);
      gap_pct = 0;
      do_req(1, 0, $urandom, 1);
      do_req(0, 1, $urandom, 0);
      do_req(1, 0, $urandom, 0);
      do_req(1, 1, $urandom, 0);
      for (int t = 0; t < 20; t++) begin
        gap_pct = $urandom_range(0, 60);
        r = $urandom_range(0, 1);
        w = r ? ($urandom_range(0, 3) == 0) : 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_req(r, w, $urandom, 0);
      end
      repeat (5) @(negedge clk);
      chk("no_pending_resp", exp_kind_q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int c;
    c = 0;
    while (c < 60000 && !(g_cfg[0].fin && g_cfg[1].fin)) begin
      @(posedge clk);
      c++;
    end
    chk("bench_completed", c < 60000, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
